// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, instruction codes and DR select type
// Shared by the TAP FSM, the top level and anything decoding state_o.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_TLR      = 4'd0,
    ST_RTI      = 4'd1,
    ST_SEL_DR   = 4'd2,
    ST_CAP_DR   = 4'd3,
    ST_SHIFT_DR = 4'd4,
    ST_EXIT1_DR = 4'd5,
    ST_PAUSE_DR = 4'd6,
    ST_EXIT2_DR = 4'd7,
    ST_UPD_DR   = 4'd8,
    ST_SEL_IR   = 4'd9,
    ST_CAP_IR   = 4'd10,
    ST_SHIFT_IR = 4'd11,
    ST_EXIT1_IR = 4'd12,
    ST_PAUSE_IR = 4'd13,
    ST_EXIT2_IR = 4'd14,
    ST_UPD_IR   = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_BSR,
    DR_USER
  } dr_sel_e;

  localparam logic [31:0] INST_BYPASS         = 32'hFFFF_FFFF;
  localparam logic [31:0] INST_IDCODE         = 32'd1;
  localparam logic [31:0] INST_SAMPLE_PRELOAD = 32'd2;
  localparam logic [31:0] INST_EXTEST         = 32'd3;
  localparam logic [31:0] INST_INTEST         = 32'd4;
  localparam logic [31:0] INST_USER_BASE      = 32'd8;

  // Truncates an instruction code to an IR of ir_w bits (BYPASS becomes all ones).
  function automatic logic [31:0] inst_code(input int unsigned ir_w, input logic [31:0] code);
    logic [31:0] mask;
    mask = (ir_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ir_w) - 32'd1);
    return code & mask;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller with registered phase strobes
// Strobes are registered from the next state, so they track state_o exactly.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_e state_o,
  output logic       tlr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o
);

  tap_state_e state_q, state_d;
  logic tlr_q, cap_ir_q, shift_ir_q, upd_ir_q, cap_dr_q, shift_dr_q, upd_dr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_d = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_d = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
    endcase
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_TLR;
      tlr_q      <= 1'b1;
      cap_ir_q   <= 1'b0;
      shift_ir_q <= 1'b0;
      upd_ir_q   <= 1'b0;
      cap_dr_q   <= 1'b0;
      shift_dr_q <= 1'b0;
      upd_dr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tlr_q      <= (state_d == ST_TLR);
      cap_ir_q   <= (state_d == ST_CAP_IR);
      shift_ir_q <= (state_d == ST_SHIFT_IR);
      upd_ir_q   <= (state_d == ST_UPD_IR);
      cap_dr_q   <= (state_d == ST_CAP_DR);
      shift_dr_q <= (state_d == ST_SHIFT_DR);
      upd_dr_q   <= (state_d == ST_UPD_DR);
    end
  end

  assign state_o      = state_q;
  assign tlr_o        = tlr_q;
  assign capture_ir_o = cap_ir_q;
  assign shift_ir_o   = shift_ir_q;
  assign update_ir_o  = upd_ir_q;
  assign capture_dr_o = cap_dr_q;
  assign shift_dr_o   = shift_dr_q;
  assign update_dr_o  = upd_dr_q;

endmodule

// File: rtl/jtag_tap_param.sv
// rtl/jtag_tap_param.sv - parametrised TAP: IR, DR mux, BSR and user update latches
// Shift registers move on posedge tck; tdo and every update latch move on negedge tck.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned IR_W   = 5,
  parameter logic [31:0] IDCODE = 32'hDEADBEEF,
  parameter int unsigned BSR_W  = 10,
  parameter int unsigned N_USER = 2,
  parameter int unsigned USER_W = 8
) (
  input  logic                     tck,
  input  logic                     rst_n,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  input  logic [BSR_W-1:0]         bsr_pi,
  output logic [BSR_W-1:0]         bsr_po,
  output logic                     extest_o,
  output logic                     intest_o,
  input  logic [N_USER*USER_W-1:0] user_pi,
  output logic [N_USER*USER_W-1:0] user_po,
  output logic [N_USER-1:0]        user_upd,
  output logic [IR_W-1:0]          ir_o,
  output logic [3:0]               state_o
);

  localparam int unsigned UW_ALL = N_USER * USER_W;
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(inst_code(IR_W, INST_IDCODE));

  tap_state_e state;
  logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_fsm (
    .tck          (tck),
    .rst_n        (rst_n),
    .tms          (tms),
    .state_o      (state),
    .tlr_o        (tlr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr)
  );

  logic [IR_W-1:0]   ir_sr_q, ir_sr_d, ir_q, ir_d;
  logic              byp_q, byp_d;
  logic [31:0]       id_sr_q, id_sr_d;
  logic [BSR_W-1:0]  bsr_sr_q, bsr_sr_d, bsr_po_q, bsr_po_d;
  logic [UW_ALL-1:0] user_sr_q, user_sr_d, user_po_q, user_po_d;
  logic [N_USER-1:0] user_upd_q, user_upd_d, user_sel;
  logic              tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic              ir_is_bypass;
  logic [31:0]       ir_ext;
  dr_sel_e           dr_sel;

  // Codes wider than the IR can never match, and all-ones always wins as BYPASS.
  assign ir_ext       = 32'(ir_q);
  assign ir_is_bypass = &ir_q;

  always_comb begin
    dr_sel   = DR_BYPASS;
    user_sel = '0;
    if (!ir_is_bypass) begin
      if (ir_ext == INST_IDCODE) begin
        dr_sel = DR_IDCODE;
      end else if (ir_ext == INST_SAMPLE_PRELOAD || ir_ext == INST_EXTEST ||
                   ir_ext == INST_INTEST) begin
        dr_sel = DR_BSR;
      end else begin
        for (int unsigned k = 0; k < N_USER; k++) begin
          if (ir_ext == INST_USER_BASE + k) begin
            dr_sel      = DR_USER;
            user_sel[k] = 1'b1;
          end
        end
      end
    end
  end

  assign extest_o = !ir_is_bypass && (ir_ext == INST_EXTEST);
  assign intest_o = !ir_is_bypass && (ir_ext == INST_INTEST);

  always_comb begin
    ir_sr_d = ir_sr_q;
    if (capture_ir) begin
      ir_sr_d = IR_W'(2'b01);
    end else if (shift_ir) begin
      ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
    end
  end

  // Only the register selected by the active instruction captures or shifts.
  always_comb begin
    byp_d     = byp_q;
    id_sr_d   = id_sr_q;
    bsr_sr_d  = bsr_sr_q;
    user_sr_d = user_sr_q;
    if (capture_dr) begin
      case (dr_sel)
        DR_BYPASS: byp_d    = 1'b0;
        DR_IDCODE: id_sr_d  = IDCODE;
        DR_BSR:    bsr_sr_d = bsr_pi;
        DR_USER: begin
          for (int unsigned k = 0; k < N_USER; k++) begin
            if (user_sel[k]) user_sr_d[k*USER_W +: USER_W] = user_pi[k*USER_W +: USER_W];
          end
        end
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        DR_BYPASS: byp_d    = tdi;
        DR_IDCODE: id_sr_d  = {tdi, id_sr_q[31:1]};
        DR_BSR:    bsr_sr_d = (bsr_sr_q >> 1) | (BSR_W'(tdi) << (BSR_W - 1));
        DR_USER: begin
          for (int unsigned k = 0; k < N_USER; k++) begin
            if (user_sel[k]) begin
              user_sr_d[k*USER_W +: USER_W] =
                (user_sr_q[k*USER_W +: USER_W] >> 1) | (USER_W'(tdi) << (USER_W - 1));
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = shift_ir | shift_dr;
    if (shift_ir) begin
      tdo_d = ir_sr_q[0];
    end else if (shift_dr) begin
      case (dr_sel)
        DR_BYPASS: tdo_d = byp_q;
        DR_IDCODE: tdo_d = id_sr_q[0];
        DR_BSR:    tdo_d = bsr_sr_q[0];
        DR_USER: begin
          for (int unsigned k = 0; k < N_USER; k++) begin
            if (user_sel[k]) tdo_d = user_sr_q[k*USER_W];
          end
        end
      endcase
    end
  end

  always_comb begin
    ir_d       = ir_q;
    bsr_po_d   = bsr_po_q;
    user_po_d  = user_po_q;
    user_upd_d = '0;
    if (tlr) begin
      ir_d      = IR_IDCODE;
      bsr_po_d  = '0;
      user_po_d = '0;
    end else if (update_ir) begin
      ir_d = ir_sr_q;
    end else if (update_dr) begin
      if (dr_sel == DR_BSR) bsr_po_d = bsr_sr_q;
      if (dr_sel == DR_USER) begin
        user_upd_d = user_sel;
        for (int unsigned k = 0; k < N_USER; k++) begin
          if (user_sel[k]) user_po_d[k*USER_W +: USER_W] = user_sr_q[k*USER_W +: USER_W];
        end
      end
    end
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      ir_sr_q   <= '0;
      byp_q     <= 1'b0;
      id_sr_q   <= '0;
      bsr_sr_q  <= '0;
      user_sr_q <= '0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      byp_q     <= byp_d;
      id_sr_q   <= id_sr_d;
      bsr_sr_q  <= bsr_sr_d;
      user_sr_q <= user_sr_d;
    end
  end

  // user_upd is rebuilt every negedge, so a pulse lasts exactly one tck period.
  always_ff @(negedge tck or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= IR_IDCODE;
      bsr_po_q   <= '0;
      user_po_q  <= '0;
      user_upd_q <= '0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      bsr_po_q   <= bsr_po_d;
      user_po_q  <= user_po_d;
      user_upd_q <= user_upd_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  assign tdo      = tdo_q;
  assign tdo_en   = tdo_en_q;
  assign bsr_po   = bsr_po_q;
  assign user_po  = user_po_q;
  assign user_upd = user_upd_q;
  assign ir_o     = ir_q;
  assign state_o  = state;

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb/tb_jtag_tap_param.sv - directed bench with a bit-array TAP model checked every cycle
module tb_jtag_tap_param;
  import jtag_pkg::*;

  localparam int IR_W = 5, BSR_W = 10, N_USER = 2, USER_W = 8;
  localparam logic [31:0] IDC = 32'hDEADBEEF;
  localparam int R_IR = 0, R_BYP = 1, R_ID = 2, R_BSR = 3, R_U0 = 4;

  logic tck = 1'b0, rst_n, tms, tdi;
  logic tdo, tdo_en, extest_o, intest_o;
  logic [BSR_W-1:0] bsr_pi, bsr_po;
  logic [N_USER*USER_W-1:0] user_pi, user_po;
  logic [N_USER-1:0] user_upd;
  logic [IR_W-1:0] ir_o;
  logic [3:0] state_o;

  jtag_tap_param dut (
    .tck(tck), .rst_n(rst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bsr_pi(bsr_pi), .bsr_po(bsr_po), .extest_o(extest_o), .intest_o(intest_o),
    .user_pi(user_pi), .user_po(user_po), .user_upd(user_upd), .ir_o(ir_o), .state_o(state_o)
  );

  always #5 tck = ~tck;

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: standard TAP graph as a table, each register as an LSB-first bit array.
  int nxt[16][2] = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
                     '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};
  int m_w[6] = '{IR_W, 1, 32, BSR_W, USER_W, USER_W};
  bit m_bits[6][32];
  int m_state;
  logic [IR_W-1:0] m_ir;
  logic [BSR_W-1:0] m_bsr_po;
  logic [N_USER*USER_W-1:0] m_user_po;
  logic [N_USER-1:0] m_upd;
  logic m_tdo, m_tdo_en;

  function automatic int sel_reg(input logic [IR_W-1:0] ir);
    if (ir == '1) return R_BYP;
    if (ir == 1) return R_ID;
    if (ir inside {2, 3, 4}) return R_BSR;
    if (ir >= 8 && ir < 8 + N_USER) return R_U0 + (int'(ir) - 8);
    return R_BYP;
  endfunction

  function automatic logic [31:0] cap_val(input int r);
    if (r == R_ID) return IDC;
    if (r == R_BSR) return 32'(bsr_pi);
    if (r >= R_U0) return 32'(user_pi[(r - R_U0)*USER_W +: USER_W]);
    return 32'd0;
  endfunction

  function automatic logic [31:0] pack(input int r);
    logic [31:0] v = 0;
    for (int i = 0; i < m_w[r]; i++) v[i] = m_bits[r][i];
    return v;
  endfunction

  task automatic load(input int r, input logic [31:0] v);
    for (int i = 0; i < m_w[r]; i++) m_bits[r][i] = v[i];
  endtask

  task automatic shift(input int r, input bit d);
    for (int i = 0; i < m_w[r] - 1; i++) m_bits[r][i] = m_bits[r][i+1];
    m_bits[r][m_w[r]-1] = d;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 6; r++) load(r, 32'd0);
    m_state = 0; m_ir = 1; m_bsr_po = 0; m_user_po = 0; m_upd = 0; m_tdo = 0; m_tdo_en = 0;
  endtask

  always @(posedge tck or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      if (m_state == 10) load(R_IR, 32'd1);
      if (m_state == 11) shift(R_IR, tdi);
      if (m_state == 3) load(sel_reg(m_ir), cap_val(sel_reg(m_ir)));
      if (m_state == 4) shift(sel_reg(m_ir), tdi);
      m_state = nxt[m_state][tms];
    end
  end

  always @(negedge tck) begin
    int r;
    if (rst_n) begin
      r = sel_reg(m_ir);
      m_tdo_en = (m_state == 11 || m_state == 4);
      m_tdo = (m_state == 11) ? m_bits[R_IR][0] : (m_state == 4) ? m_bits[r][0] : 1'b0;
      m_upd = 0;
      if (m_state == 0) begin
        m_ir = 1; m_bsr_po = 0; m_user_po = 0;
      end else if (m_state == 15) begin
        m_ir = IR_W'(pack(R_IR));
      end else if (m_state == 8) begin
        if (r == R_BSR) m_bsr_po = BSR_W'(pack(R_BSR));
        if (r >= R_U0) begin
          m_user_po[(r - R_U0)*USER_W +: USER_W] = USER_W'(pack(r));
          m_upd[r - R_U0] = 1'b1;
        end
      end
    end
  end

  always @(negedge tck) begin
    #2;
    if (rst_n) begin
      chk("state_o", 64'(state_o), 64'(m_state));
      chk("ir_o", 64'(ir_o), 64'(m_ir));
      chk("tdo", 64'(tdo), 64'(m_tdo));
      chk("tdo_en", 64'(tdo_en), 64'(m_tdo_en));
      chk("bsr_po", 64'(bsr_po), 64'(m_bsr_po));
      chk("user_po", 64'(user_po), 64'(m_user_po));
      chk("user_upd", 64'(user_upd), 64'(m_upd));
      chk("extest_o", 64'(extest_o), 64'(m_ir == 3));
      chk("intest_o", 64'(intest_o), 64'(m_ir == 4));
    end
  end

  task automatic tick(input logic t, input logic d);
    tms = t; tdi = d;
    @(posedge tck); @(negedge tck); #3;
  endtask

  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                          output logic [1:0] upd_at, output logic [1:0] upd_after);
    tick(1, 0); tick(0, 0); tick(0, 0);
    dout = 0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0); upd_at = user_upd;
    tick(0, 0); upd_after = user_upd;
  endtask

  task automatic shift_ir(input logic [IR_W-1:0] code, output logic [IR_W-1:0] cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    cap = 0;
    for (int i = 0; i < IR_W; i++) begin
      cap[i] = tdo;
      tick(i == IR_W - 1, code[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0] ua, ub;
    logic [IR_W-1:0] c;
    rst_n = 0; tms = 1; tdi = 0; bsr_pi = 0; user_pi = 0;
    model_reset();
    repeat (2) @(negedge tck);
    #3;
    chk("rst state_o", 64'(state_o), 64'd0);
    chk("rst ir_o", 64'(ir_o), 64'd1);
    chk("rst tdo/tdo_en", 64'({tdo, tdo_en}), 64'd0);
    chk("rst bsr_po", 64'(bsr_po), 64'd0);
    chk("rst user_po/upd", 64'({user_po, user_upd}), 64'd0);
    chk("rst extest/intest", 64'({extest_o, intest_o}), 64'd0);
    rst_n = 1;
    tick(1, 0);
    tick(0, 0);

    shift_dr(32, 32'h0, d, ua, ub);
    chk("idcode stream", 64'(d), 64'hDEADBEEF);

    tick(1, 0); tick(0, 0); tick(0, 0);
    repeat (5) tick(1, 0);
    chk("5xtms state TLR", 64'(state_o), 64'd0);
    chk("5xtms ir IDCODE", 64'(ir_o), 64'd1);
    tick(0, 0);

    shift_ir(5'h1F, c);
    chk("ir capture bits", 64'(c), 64'h01);
    chk("ir_o bypass", 64'(ir_o), 64'h1F);
    shift_dr(5, 32'b01101, d, ua, ub);
    chk("bypass delay", 64'(d), 64'b11010);

    shift_ir(5'h0A, c);
    shift_dr(5, 32'b01101, d, ua, ub);
    chk("undef code bypass", 64'(d), 64'b11010);

    shift_ir(5'h02, c);
    bsr_pi = 10'h2A5;
    shift_dr(10, 32'h15A, d, ua, ub);
    chk("bsr sample", 64'(d), 64'h2A5);
    chk("bsr preload", 64'(bsr_po), 64'h15A);
    chk("extest off", 64'(extest_o), 64'd0);
    shift_ir(5'h03, c);
    chk("extest on", 64'(extest_o), 64'd1);
    chk("bsr_po held", 64'(bsr_po), 64'h15A);

    user_pi = {8'hC3, 8'h77};
    shift_ir(5'h08, c);
    shift_dr(8, 32'hA6, d, ua, ub);
    chk("user0 capture", 64'(d), 64'h77);
    chk("user0 po", 64'(user_po), 64'h00A6);
    chk("user0 upd pulse", 64'({ua, ub}), 64'b0100);
    shift_ir(5'h09, c);
    shift_dr(8, 32'h5E, d, ua, ub);
    chk("user1 capture", 64'(d), 64'hC3);
    chk("user1 po", 64'(user_po), 64'h5EA6);
    chk("user1 upd pulse", 64'({ua, ub}), 64'b1000);

    shift_ir(5'h04, c);
    chk("intest on", 64'({extest_o, intest_o}), 64'b01);

    shift_ir(5'h02, c);
    tick(1, 0); tick(0, 0); tick(0, 0);
    repeat (4) tick(0, 1);
    chk("mid-shift tdo_en", 64'(tdo_en), 64'd1);
    rst_n = 0;
    #1;
    chk("async rst bsr_po", 64'(bsr_po), 64'd0);
    chk("async rst ir_o", 64'(ir_o), 64'd1);
    chk("async rst tdo_en", 64'(tdo_en), 64'd0);
    chk("async rst state", 64'(state_o), 64'd0);
    @(negedge tck); #3;
    rst_n = 1;
    tick(1, 0); tick(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_tap_param.md
# jtag_tap_param

Parametrised IEEE 1149.1 TAP controller: the next generation of the lab TAP, with configurable IR length, IDCODE, boundary-scan length and N user data registers. It sits between the board JTAG pins and the design under test. It exposes the boundary-scan register, user-register capture/update ports and a decoded instruction/mode interface. All logic is clocked by tck; there is no system-clock domain inside the block.

## Interface
Parameters:
- IR_W, 5: instruction register length, ≥2.
- IDCODE, 32'hDEADBEEF: device ID; bit 0 must be 1.
- BSR_W, 10: boundary-scan register length, ≥1.
- N_USER, 2: number of user data registers, 1..8.
- USER_W, 8: width of each user register, ≥1.

Ports:
- tck  in  1  JTAG test clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tms  in  1  test mode select, sampled on posedge tck.
- tdi  in  1  test data in, sampled on posedge tck.
- tdo  out  1  test data out, changes on negedge tck.
- tdo_en  out  1  high while tdo is valid (Shift-IR/Shift-DR).
- bsr_pi  in  BSR_W  parallel values captured into the BSR.
- bsr_po  out  BSR_W  BSR update latch.
- extest_o  out  1  EXTEST active; pads drive bsr_po.
- intest_o  out  1  INTEST active; core inputs take bsr_po.
- user_pi  in  N_USER*USER_W  capture values; slice k belongs to user register k.
- user_po  out  N_USER*USER_W  user update latches.
- user_upd  out  N_USER  one-tck pulse per register on update.
- ir_o  out  IR_W  active instruction.
- state_o  out  4  current TAP state (package encoding).

## Operation
- FSM: the 16 standard TAP states, with standard transitions on tms at posedge tck.
- Five consecutive tms=1 reach Test-Logic-Reset (TLR) from any state. This is inherent to the graph; no separate counter is used.
- Instruction codes:
  - BYPASS = all ones.
  - IDCODE = 1.
  - SAMPLE_PRELOAD = 2.
  - EXTEST = 3.
  - INTEST = 4.
  - USERk = 8+k.
  - Any unlisted code selects BYPASS.
- IR shift register:
  - Capture-IR loads {0…, 2'b01}.
  - Shift-IR shifts right; tdi enters the MSB and the LSB goes to tdo.
- IR update latch:
  - Loaded on the negedge in Update-IR.
  - Forced to IDCODE on the negedge while in TLR.
- Capture-DR loads the selected register:
  - BYPASS: 0.
  - IDCODE: IDCODE.
  - SAMPLE_PRELOAD/EXTEST/INTEST: bsr_pi.
  - USERk: slice k of user_pi.
- Shift-DR shifts the selected register LSB-first, tdi into the MSB. Unselected registers hold their value.
- Update-DR, on the negedge:
  - BSR instructions: bsr_po ← BSR shift register.
  - USERk: user_po slice k ← shift register, and user_upd[k]=1 for exactly one tck period.
  - IDCODE and BYPASS: no update.
- TLR (held on negedge):
  - bsr_po = 0, user_po = 0, user_upd = 0.
  - extest_o = intest_o = 0.
- extest_o/intest_o decode from ir_o; both are combinational from the latch.

## Timing
- Reset values:
  - state_o = TLR.
  - ir_o = IDCODE.
  - tdo = 0, tdo_en = 0.
  - bsr_po = 0, user_po = 0, user_upd = 0.
  - extest_o = 0, intest_o = 0.
  - Shift registers = 0.
- rst_n mid-shift: immediate asynchronous return to the reset values. The partial shift is discarded and no update occurs.
- tdo/tdo_en:
  - Registered on negedge.
  - tdo = LSB of the active shift register during Shift-IR/Shift-DR; otherwise tdo = 0 and tdo_en = 0.
  - The first shifted bit appears on the negedge after entering Shift.
- Latency:
  - BYPASS: tdi→tdo delay is 1 tck.
  - IDCODE: 32 bits appear over 32 consecutive Shift-DR cycles.
- Update latches change only on the negedge of Update-IR/Update-DR. Outputs are stable for a full posedge-to-posedge window.
- Exit1 directly to Update skips Pause: valid, and the update is still performed.
- Pause states hold the shift contents indefinitely.

## Structure
- Package jtag_pkg holds:
  - tap_state_e (4-bit enum, TLR = 4'd0).
  - Instruction code constants INST_BYPASS/IDCODE/SAMPLE_PRELOAD/EXTEST/INTEST/USER_BASE, sized by IR_W via a function.
- Sub-module jtag_tap_fsm: tck, rst_n, tms → state and the one-hot strobes capture/shift/update for IR and DR.
- The top level holds the IR, the DR mux and the update latches.

## Test plan
- Reset behaviour:
  - After rst_n release, go to Shift-DR and shift 32 bits → tdo sequence 0xDEADBEEF LSB-first.
  - From Shift-DR, apply tms=1 for 5 tck → state_o = TLR and ir_o = IDCODE.
- IR capture: Shift-IR with IR_W=5 → first 5 tdo bits 1,0,0,0,0. Load 5'h1F → ir_o = 5'h1F after Update-IR.
- BYPASS: shift tdi 1,0,1,1 → tdo 0,1,0,1,1 (one-bit delay). Loading undefined code 5'h0A also behaves as BYPASS.
- SAMPLE_PRELOAD then EXTEST:
  - With bsr_pi = 10'h2A5, shift → tdo reads 10'h2A5.
  - Preload 10'h15A → bsr_po = 10'h15A.
  - Select EXTEST → extest_o = 1.
- USER1:
  - With user_pi slice 1 = 8'hC3, shift in 8'h5E → tdo reads 8'hC3.
  - At Update-DR: user_po slice 1 = 8'h5E, user_upd = 2'b10 for one tck, and slice 0 is unchanged.
- Reset during BSR shift: assert rst_n low after 4 Shift-DR bits → bsr_po = 0, ir_o = IDCODE, tdo_en = 0 immediately.
